// File: rtl/breakout_pkg.sv
// rtl/breakout_pkg.sv - shared constants, collision codes and FSM states for the ball sequencer
package breakout_pkg;

    localparam int SCREEN_W_DEF  = 640;
    localparam int SCREEN_H_DEF  = 480;
    localparam int BALL_SIZE_DEF = 4;

    // dir[0] set = moving -x, dir[1] set = moving -y
    localparam int         DIR_NEG_X_BIT = 0;
    localparam int         DIR_NEG_Y_BIT = 1;
    localparam logic [1:0] DIR_UP_LEFT   = 2'b11;

    localparam logic [1:0] COLL_NONE = 2'b00;
    localparam logic [1:0] COLL_X    = 2'b10;
    localparam logic [1:0] COLL_Y    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_TICK,
        ST_CALC,
        ST_QUERY,
        ST_RESOLVE,
        ST_COMMIT
    } state_e;

endpackage

// File: rtl/ball_next_pos.sv
// rtl/ball_next_pos.sv - one-axis signed step, clamp and wall flags
module ball_next_pos
    import breakout_pkg::*;
#(
    parameter int LIMIT = SCREEN_W_DEF - BALL_SIZE_DEF
)(
    input  logic [9:0] pos_i,
    input  logic [6:0] step_i,
    input  logic       neg_i,
    output logic [9:0] next_o,
    output logic [9:0] clamped_o,
    output logic       under_o,
    output logic       over_o
);

    localparam logic signed [10:0] LIM = 11'(LIMIT);

    logic signed [10:0] pos_s;
    logic signed [10:0] step_s;
    logic signed [10:0] next_s;

    assign pos_s  = signed'({1'b0, pos_i});
    assign step_s = signed'({4'b0000, step_i});
    assign next_s = neg_i ? (pos_s - step_s) : (pos_s + step_s);

    assign under_o   = (next_s < 11'sd0);
    assign over_o    = (next_s > LIM);
    assign next_o    = next_s[9:0];
    assign clamped_o = under_o ? 10'd0 : (over_o ? LIM[9:0] : next_s[9:0]);

endmodule

// File: rtl/ball_motion_ctrl.sv
// rtl/ball_motion_ctrl.sv - per-frame ball sequencer: query checker, resolve walls/bricks, commit
// Optional speed-up on brick hits when BALL_SPEEDUP_EN is defined.
module ball_motion_ctrl
    import breakout_pkg::*;
#(
    parameter int SCREEN_W     = SCREEN_W_DEF,
    parameter int SCREEN_H     = SCREEN_H_DEF,
    parameter int BALL_SIZE    = BALL_SIZE_DEF,
    parameter int START_X      = 318,
    parameter int START_Y      = 400,
    parameter int STEP_INIT    = 2,
    parameter int COLL_TIMEOUT = 15
)(
    input  logic       clk,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic       launch,
    output logic       query_valid,
    output logic [9:0] query_x,
    output logic [9:0] query_y,
    output logic [6:0] xstep,
    output logic [6:0] ystep,
    input  logic       coll_valid,
    input  logic [1:0] coll_code,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [1:0] dir,
    output logic       pos_valid,
    output logic       ball_lost,
    output logic       busy
);

    localparam int         TW        = $clog2(COLL_TIMEOUT + 1);
    localparam logic [9:0] START_X_V = 10'(START_X);
    localparam logic [9:0] START_Y_V = 10'(START_Y);

    state_e state_q, state_d;

    logic [9:0]    ball_x_q, ball_y_q, query_x_q, query_y_q, new_x_q, new_y_q;
    logic [1:0]    dir_q, coll_q;
    logic [TW-1:0] tmo_q;
    logic          pos_valid_q, ball_lost_q;
    logic [6:0]    step_w;
    logic [9:0]    nx, ny, x_clamped, y_clamped;
    logic          x_under, x_over, y_under, y_over;
    logic          tmo_done, brick_x, brick_y, flip_x, flip_y;

    ball_next_pos #(.LIMIT(SCREEN_W - BALL_SIZE)) u_next_x (
        .pos_i(ball_x_q), .step_i(step_w), .neg_i(dir_q[DIR_NEG_X_BIT]),
        .next_o(nx), .clamped_o(x_clamped), .under_o(x_under), .over_o(x_over)
    );

    ball_next_pos #(.LIMIT(SCREEN_H - BALL_SIZE)) u_next_y (
        .pos_i(ball_y_q), .step_i(step_w), .neg_i(dir_q[DIR_NEG_Y_BIT]),
        .next_o(ny), .clamped_o(y_clamped), .under_o(y_under), .over_o(y_over)
    );

    assign tmo_done = (tmo_q == TW'(COLL_TIMEOUT - 1));
    assign brick_x  = (coll_q == COLL_X);
    assign brick_y  = (coll_q == COLL_Y);
    // wall and brick on the same axis collapse into a single flip
    assign flip_x   = x_under | x_over | brick_x;
    assign flip_y   = y_under | brick_y;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (launch)                  state_d = ST_WAIT_TICK;
            ST_WAIT_TICK: if (frame_tick)              state_d = ST_CALC;
            ST_CALC:                                   state_d = ST_QUERY;
            ST_QUERY:     if (coll_valid || tmo_done)  state_d = ST_RESOLVE;
            ST_RESOLVE:   state_d = y_over ? ST_IDLE : ST_COMMIT;
            ST_COMMIT:                                 state_d = ST_WAIT_TICK;
            default:                                   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        query_valid = (state_q == ST_QUERY);
        busy        = !((state_q == ST_IDLE) || (state_q == ST_WAIT_TICK));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ball_x_q    <= START_X_V;
            ball_y_q    <= START_Y_V;
            dir_q       <= DIR_UP_LEFT;
            query_x_q   <= 10'd0;
            query_y_q   <= 10'd0;
            new_x_q     <= START_X_V;
            new_y_q     <= START_Y_V;
            coll_q      <= COLL_NONE;
            tmo_q       <= '0;
            pos_valid_q <= 1'b0;
            ball_lost_q <= 1'b0;
        end else begin
            pos_valid_q <= 1'b0;
            ball_lost_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (launch) begin
                    ball_x_q <= START_X_V;
                    ball_y_q <= START_Y_V;
                    dir_q    <= DIR_UP_LEFT;
                end
                ST_CALC: begin
                    query_x_q <= nx;
                    query_y_q <= ny;
                    tmo_q     <= '0;
                end
                ST_QUERY: begin
                    if (coll_valid)    coll_q <= coll_code;
                    else if (tmo_done) coll_q <= COLL_NONE;
                    else               tmo_q  <= tmo_q + 1'b1;
                end
                ST_RESOLVE: begin
                    if (y_over) begin
                        ball_lost_q <= 1'b1;
                        ball_x_q    <= START_X_V;
                        ball_y_q    <= START_Y_V;
                        dir_q       <= DIR_UP_LEFT;
                    end else begin
                        dir_q   <= dir_q ^ {flip_y, flip_x};
                        new_x_q <= brick_x ? ball_x_q : x_clamped;
                        new_y_q <= brick_y ? ball_y_q : y_clamped;
                    end
                end
                ST_COMMIT: begin
                    ball_x_q    <= new_x_q;
                    ball_y_q    <= new_y_q;
                    pos_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef BALL_SPEEDUP_EN
    logic [3:0] hits_q;
    logic [6:0] step_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hits_q <= 4'd0;
            step_q <= 7'(STEP_INIT);
        end else if ((state_q == ST_IDLE) && launch) begin
            hits_q <= 4'd0;
            step_q <= 7'(STEP_INIT);
        end else if ((state_q == ST_RESOLVE) && !y_over && (brick_x || brick_y)) begin
            hits_q <= hits_q + 4'd1;
            if ((hits_q == 4'd15) && (step_q < 7'd6)) step_q <= step_q + 7'd1;
        end
    end

    assign step_w = step_q;
`else
    assign step_w = 7'(STEP_INIT);
`endif

    assign query_x   = query_x_q;
    assign query_y   = query_y_q;
    assign xstep     = step_w;
    assign ystep     = step_w;
    assign ball_x    = ball_x_q;
    assign ball_y    = ball_y_q;
    assign dir       = dir_q;
    assign pos_valid = pos_valid_q;
    assign ball_lost = ball_lost_q;

endmodule
